// File: rtl/half_rate_tracker_pkg.sv
// Shared types and constants for the clock-recovery path.
package clks_alot_p;

  localparam int COUNTER_WIDTH = 8;

  typedef enum logic [1:0] {
    TRK_IDLE    = 2'd0,
    TRK_ARM     = 2'd1,
    TRK_ACQUIRE = 2'd2,
    TRK_LOCKED  = 2'd3
  } tracker_state_e;

  typedef struct packed {
    logic locked;
    logic drift_valid;
    logic drift_up;
    logic glitch;
    logic stall;
  } tracker_status_s;

endpackage

// File: rtl/half_rate_tracker_interval_counter.sv
// Saturating sys-clock interval counter; the value seen on an edge cycle is
// the interval measurement (edges at t0, t1 give t1-t0-1).
module interval_counter
  import clks_alot_p::*;
#(
  parameter int CW = COUNTER_WIDTH
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          clk_en_i,
  input  logic          edge_valid_i,
  output logic [CW-1:0] meas_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: restart on an edge, otherwise count up and stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (edge_valid_i) begin
      count_d = '0;
    end else if (count_q == {CW{1'b1}}) begin
      count_d = count_q;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register, advanced only on qualified cycles.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      count_q <= '0;
    end else if (clk_en_i) begin
      count_q <= count_d;
    end
  end

  assign meas_o = count_q;

endmodule

// File: rtl/half_rate_tracker.sv
// Tracks the half-rate of recovered edges: acquires a consistent interval,
// locks, then follows small drift with a rounded running average.
module half_rate_tracker
  import clks_alot_p::*;
#(
  parameter int CW          = COUNTER_WIDTH,
  parameter int LOCK_HALVES = 4,
  parameter int TOLERANCE   = 2
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          clk_en_i,
  input  logic          track_en_i,
  input  logic          edge_valid_i,
  input  logic [CW-1:0] min_half_m1_i,
  input  logic [CW-1:0] max_half_m1_i,
  output logic [CW-1:0] half_rate_m1_o,
  output logic          locked_o,
  output logic          drift_valid_o,
  output logic          drift_up_o,
  output logic          glitch_o,
  output logic          stall_o,
  output logic          busy_o
);

  localparam int              CNT_W    = $clog2(LOCK_HALVES + 1);
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_HALVES);
  localparam logic [CW-1:0]    TOL      = CW'(TOLERANCE);

  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [CW-1:0]   meas_s;
  logic            below_s;
  logic            above_s;
  logic            close_s;
  logic            at_max_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CW:0]     avg_s;

  tracker_state_e  state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CW-1:0]   hr_q,     hr_d;
  tracker_status_s status_q, status_d;
  logic            busy_q,   busy_d;

  interval_counter #(.CW(CW)) u_interval_counter (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .clk_en_i     (clk_en_i),
    .edge_valid_i (edge_valid_i),
    .meas_o       (meas_s)
  );

  // Interval classification against the legal window and the tracked rate.
  always_comb begin
    below_s   = (meas_s < min_half_m1_i);
    above_s   = (meas_s > max_half_m1_i);
    at_max_s  = (meas_s == max_half_m1_i);
    close_s   = (abs_diff(meas_s, hr_q) <= TOL);
    cnt_inc_s = (close_s && (cnt_q != '0)) ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
    avg_s     = ({1'b0, hr_q} + {1'b0, meas_s} + {{CW{1'b0}}, 1'b1}) >> 1;
  end

  // Tracking FSM next-state, rate update and pulse generation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    hr_d            = hr_q;
    status_d        = '0;
    status_d.locked = status_q.locked;
    if (!track_en_i) begin
      // Disable overrides any edge or violation on the same cycle.
      state_d         = TRK_IDLE;
      cnt_d           = '0;
      hr_d            = '0;
      status_d.locked = 1'b0;
    end else begin
      case (state_q)
        TRK_IDLE: begin
          state_d = TRK_ARM;
        end
        TRK_ARM: begin
          if (edge_valid_i) begin
            state_d = TRK_ACQUIRE;
            cnt_d   = '0;
          end else begin
            state_d = TRK_ARM;
          end
        end
        TRK_ACQUIRE, TRK_LOCKED: begin
          if (edge_valid_i) begin
            if (below_s) begin
              status_d.glitch = 1'b1;
              status_d.locked = 1'b0;
              state_d         = TRK_ARM;
              cnt_d           = '0;
            end else if (above_s) begin
              // Only reachable if the window shrinks under a running interval.
              status_d.locked = 1'b0;
              state_d         = TRK_ARM;
              cnt_d           = '0;
            end else if ((state_q == TRK_LOCKED) && close_s) begin
              hr_d                 = avg_s[CW-1:0];
              status_d.drift_valid = (meas_s != hr_q);
              status_d.drift_up    = (meas_s > hr_q);
            end else begin
              // Acquisition step, or loss of lock on a large jump.
              hr_d  = meas_s;
              cnt_d = cnt_inc_s;
              if (cnt_inc_s >= LOCK_CNT) begin
                state_d         = TRK_LOCKED;
                status_d.locked = 1'b1;
              end else begin
                state_d         = TRK_ACQUIRE;
                status_d.locked = 1'b0;
              end
            end
          end else if (at_max_s) begin
            status_d.stall  = 1'b1;
            status_d.locked = 1'b0;
            state_d         = TRK_ARM;
            cnt_d           = '0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = TRK_IDLE;
        end
      endcase
    end
    busy_d = (state_d != TRK_IDLE);
  end

  // State and registered outputs, updated only on qualified cycles.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= TRK_IDLE;
      cnt_q    <= '0;
      hr_q     <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
    end else if (clk_en_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hr_q     <= hr_d;
      status_q <= status_d;
      busy_q   <= busy_d;
    end
  end

  assign half_rate_m1_o = hr_q;
  assign locked_o       = status_q.locked;
  assign drift_valid_o  = status_q.drift_valid;
  assign drift_up_o     = status_q.drift_up;
  assign glitch_o       = status_q.glitch;
  assign stall_o        = status_q.stall;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_half_rate_tracker.sv
// Directed bench for half_rate_tracker with an interval-timestamp reference model.
module tb_half_rate_tracker;
  import clks_alot_p::*;

  localparam int CW  = COUNTER_WIDTH;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          clk_en;
  logic          track_en;
  logic          edge_valid;
  logic [CW-1:0] min_h;
  logic [CW-1:0] max_h;
  logic [CW-1:0] half_rate;
  logic          locked, drift_valid, drift_up, glitch, stall, busy;

  int n_checks = 0;
  int n_fail   = 0;

  half_rate_tracker dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .clk_en_i       (clk_en),
    .track_en_i     (track_en),
    .edge_valid_i   (edge_valid),
    .min_half_m1_i  (min_h),
    .max_half_m1_i  (max_h),
    .half_rate_m1_o (half_rate),
    .locked_o       (locked),
    .drift_valid_o  (drift_valid),
    .drift_up_o     (drift_up),
    .glitch_o       (glitch),
    .stall_o        (stall),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge timestamps instead of a counter; modes 0 idle, 1 arm, 2 acquire, 3 locked.
  int m_mode, m_t, m_last, m_cnt;
  int e_hr, e_locked, e_dv, e_du, e_gl, e_st, e_busy;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_last = -1; m_cnt = 0;
    e_hr = 0; e_locked = 0; e_dv = 0; e_du = 0; e_gl = 0; e_st = 0; e_busy = 0;
  endtask

  task automatic model_step();
    int meas, diff;
    bit close;
    if (!clk_en) return;
    meas = m_t - m_last - 1;
    if (meas > SAT) meas = SAT;
    e_dv = 0; e_du = 0; e_gl = 0; e_st = 0;
    if (!track_en) begin
      m_mode = 0; m_cnt = 0; e_locked = 0; e_hr = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (edge_valid) begin m_mode = 2; m_cnt = 0; end
    end else if (edge_valid) begin
      diff  = (meas > e_hr) ? meas - e_hr : e_hr - meas;
      close = (diff <= 2);
      if (meas < int'(min_h)) begin
        e_gl = 1; m_mode = 1; m_cnt = 0; e_locked = 0;
      end else if (meas > int'(max_h)) begin
        m_mode = 1; m_cnt = 0; e_locked = 0;
      end else if (m_mode == 3 && close) begin
        if (meas != e_hr) begin e_dv = 1; e_du = (meas > e_hr); end
        e_hr = (e_hr + meas + 1) / 2;
      end else begin
        m_cnt = (close && m_cnt != 0) ? m_cnt + 1 : 1;
        e_hr  = meas;
        if (m_cnt >= 4) begin m_mode = 3; e_locked = 1; end
        else begin m_mode = 2; e_locked = 0; end
      end
    end else if (meas == int'(max_h)) begin
      e_st = 1; m_mode = 1; m_cnt = 0; e_locked = 0;
    end
    e_busy = (m_mode != 0);
    if (edge_valid) m_last = m_t;
    m_t++;
  endtask

  // Every falling edge: compare DUT against the model, then advance the model with the inputs the next rising edge will sample.
  always @(negedge clk) begin
    if (!arst_n) model_reset();
    check("cmp_half_rate", half_rate, e_hr);
    check("cmp_locked", locked, e_locked);
    check("cmp_drift_valid", drift_valid, e_dv);
    check("cmp_drift_up", drift_up, e_du);
    check("cmp_glitch", glitch, e_gl);
    check("cmp_stall", stall, e_st);
    check("cmp_busy", busy, e_busy);
    if (arst_n) model_step();
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_edge();
    edge_valid = 1'b1;
    @(posedge clk); #1;
    edge_valid = 1'b0;
  endtask

  task automatic lock_train(input int n);
    repeat (n) begin idle(9); pulse_edge(); end
  endtask

  int stall_cnt;

  initial begin
    arst_n = 1'b0; clk_en = 1'b1; track_en = 1'b0; edge_valid = 1'b0;
    min_h = CW'(4); max_h = CW'(20);
    idle(3);
    check("reset_half_rate", half_rate, 0);
    check("reset_locked", locked, 0);
    check("reset_busy", busy, 0);
    arst_n = 1'b1;
    idle(2);
    check("idle_busy", busy, 0);
    track_en = 1'b1;
    idle(2);
    check("arm_busy", busy, 1);

    // Edges every 10 cycles.
    pulse_edge();
    idle(9); pulse_edge();
    check("rate_after_2nd", half_rate, 9);
    check("unlocked_after_2nd", locked, 0);
    lock_train(3);
    check("locked_after_5th", locked, 1);
    check("rate_locked", half_rate, 9);

    // Drift up: meas 10 -> (9+10+1)>>1 = 10.
    idle(10); pulse_edge();
    check("drift_up_valid", drift_valid, 1);
    check("drift_up_dir", drift_up, 1);
    check("drift_up_rate", half_rate, 10);
    idle(1);
    check("drift_pulse_width", drift_valid, 0);
    // Drift down: meas 8 -> (10+8+1)>>1 = 9.
    idle(7); pulse_edge();
    check("drift_dn_valid", drift_valid, 1);
    check("drift_dn_dir", drift_up, 0);
    check("drift_dn_rate", half_rate, 9);

    // Glitch: meas 2 < min 4.
    idle(2); pulse_edge();
    check("glitch_pulse", glitch, 1);
    check("glitch_unlock", locked, 0);
    check("glitch_rate_held", half_rate, 9);
    check("glitch_busy", busy, 1);
    idle(1);
    check("glitch_pulse_width", glitch, 0);

    // Relock, then stop edges: stall when the counter reaches 20.
    pulse_edge(); lock_train(4);
    check("relock", locked, 1);
    idle(20);
    check("no_stall_early", stall, 0);
    idle(1);
    check("stall_pulse", stall, 1);
    check("stall_unlock", locked, 0);
    stall_cnt = 0;
    repeat (300) begin
      idle(1);
      if (stall === 1'b1) stall_cnt++;
    end
    check("stall_once", stall_cnt, 0);

    // Large jump while locked: meas 15, delta 6.
    pulse_edge(); lock_train(4);
    check("lock_before_jump", locked, 1);
    idle(15); pulse_edge();
    check("jump_unlock", locked, 0);
    check("jump_rate", half_rate, 15);
    check("jump_busy", busy, 1);

    // clk_en low freezes everything, including the counter and edges.
    clk_en = 1'b0;
    idle(3); pulse_edge(); idle(3);
    check("hold_rate", half_rate, 15);
    check("hold_busy", busy, 1);
    clk_en = 1'b1;
    pulse_edge();
    check("frozen_counter_glitch", glitch, 1);

    // Async reset in the middle of LOCKED.
    pulse_edge(); lock_train(4);
    check("lock_before_reset", locked, 1);
    arst_n = 1'b0;
    #1;
    check("async_reset_rate", half_rate, 0);
    check("async_reset_locked", locked, 0);
    check("async_reset_busy", busy, 0);
    idle(2);
    arst_n = 1'b1;
    idle(2); pulse_edge(); lock_train(4);
    check("lock_after_reset", locked, 1);

    // Disable coincident with a glitching edge: disable wins, no pulse.
    idle(2);
    track_en = 1'b0;
    pulse_edge();
    check("disable_no_glitch", glitch, 0);
    check("disable_locked", locked, 0);
    check("disable_busy", busy, 0);
    check("disable_rate", half_rate, 0);

    // min > max: measured edges glitch, idle lines stall, no lock.
    min_h = CW'(20); max_h = CW'(4);
    track_en = 1'b1;
    idle(2); pulse_edge();
    idle(2); pulse_edge();
    check("inverted_glitch", glitch, 1);
    idle(3); pulse_edge();
    idle(5);
    check("inverted_stall", stall, 1);
    check("inverted_never_locked", locked, 0);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
